// File: rtl/sprite_draw_scheduler.sv
// Round-robin owner of the single VGA plot port, shared between ROM-backed sprite drawers.
// Optional: define SPRITE_TRANSPARENCY_EN to suppress plotting of TRANSP_COLOUR pixels.
module sprite_draw_scheduler #(
  parameter int         NUM_REQ       = 4,
  parameter int         ROM_LAT       = 1,
  parameter int         TIMEOUT       = 4096,
  parameter logic [2:0] TRANSP_COLOUR = 3'b000
) (
  input  logic                 clock_all,
  input  logic                 reset_all,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   src_done,
  input  logic [9*NUM_REQ-1:0] src_x,
  input  logic [8*NUM_REQ-1:0] src_y,
  input  logic [3*NUM_REQ-1:0] src_colour,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   drawer_enable,
  output logic [8:0]           vga_x,
  output logic [7:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 done_pulse,
  output logic [2:0]           done_id,
  output logic                 timeout_err
);
  localparam int          IDX_W      = $clog2(NUM_REQ);
  localparam logic [12:0] WD_LAST    = 13'(TIMEOUT - 1);
  localparam logic [1:0]  DRAIN_LAST = 2'(ROM_LAT - 1);
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_DRAW, S_DRAIN, S_FINISH} state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] owner, owner_d, rr_ptr, rr_ptr_d, pick_idx;
  logic [12:0]      watchdog, watchdog_d;
  logic [1:0]       drain_cnt, drain_cnt_d;
  logic             timeout_d, pick_valid;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    logic [IDX_W:0] sum;
    logic [IDX_W-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    rr_ptr_d    = rr_ptr;
    watchdog_d  = watchdog;
    drain_cnt_d = drain_cnt;
    timeout_d   = timeout_err;
    unique case (state)
      S_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        watchdog_d = '0;
        state_d    = S_DRAW;
      end
      S_DRAW: begin
        watchdog_d = watchdog + 13'd1;
        if (src_done[owner]) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end else if (watchdog == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt + 2'd1;
        if (drain_cnt == DRAIN_LAST) state_d = S_FINISH;
      end
      S_FINISH: begin
        rr_ptr_d = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_all) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (reset_all) begin
      state       <= S_IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      watchdog    <= '0;
      drain_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      rr_ptr      <= rr_ptr_d;
      watchdog    <= watchdog_d;
      drain_cnt   <= drain_cnt_d;
      timeout_err <= timeout_d;
    end
  end

  always_comb begin
    grant         = '0;
    drawer_enable = '0;
    if (state inside {S_CLEAR, S_DRAW, S_DRAIN}) grant[owner] = 1'b1;
    if (state == S_DRAW) drawer_enable[owner] = 1'b1;
  end

  assign busy       = (state != S_IDLE);
  assign done_pulse = (state == S_FINISH);
  assign done_id    = done_pulse ? 3'(owner) : 3'd0;

  // Coordinate/valid delay line; its last stage is the shared output register.
  logic       valid_in, last_valid_in;
  logic [8:0] x_in;
  logic [7:0] y_in;
  logic [2:0] colour_in, colour_q;
  logic [8:0] x_pipe [ROM_LAT];
  logic [7:0] y_pipe [ROM_LAT];
  logic       v_pipe [ROM_LAT];

  assign valid_in = (state == S_DRAW);

  always_comb begin
    x_in      = '0;
    y_in      = '0;
    colour_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        x_in      = src_x[9*i +: 9];
        y_in      = src_y[8*i +: 8];
        colour_in = src_colour[3*i +: 3];
      end
    end
  end

  generate
    if (ROM_LAT == 1) begin : g_lat1
      assign last_valid_in = valid_in;
    end else begin : g_latn
      assign last_valid_in = v_pipe[ROM_LAT-2];
    end
  endgenerate

  always_ff @(posedge clock_all) begin
    // NOTE: the delay line is cleared on reset so an aborted draw cannot plot afterwards.
    if (reset_all) begin
      for (int k = 0; k < ROM_LAT; k++) begin
        x_pipe[k] <= '0;
        y_pipe[k] <= '0;
        v_pipe[k] <= 1'b0;
      end
      colour_q <= '0;
    end else begin
      x_pipe[0] <= valid_in ? x_in : '0;
      y_pipe[0] <= valid_in ? y_in : '0;
      v_pipe[0] <= valid_in;
      for (int k = 1; k < ROM_LAT; k++) begin
        x_pipe[k] <= x_pipe[k-1];
        y_pipe[k] <= y_pipe[k-1];
        v_pipe[k] <= v_pipe[k-1];
      end
      colour_q <= last_valid_in ? colour_in : '0;
      if (TRANSP_EN && colour_in == TRANSP_COLOUR) v_pipe[ROM_LAT-1] <= 1'b0;
    end
  end

  assign vga_x      = x_pipe[ROM_LAT-1];
  assign vga_y      = y_pipe[ROM_LAT-1];
  assign vga_colour = colour_q;
  assign vga_plot   = v_pipe[ROM_LAT-1];

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Scoreboard bench for sprite_draw_scheduler: drawer models feed expected pixels/done ids to queues.
// Build with SPRITE_TRANSPARENCY_EN defined to exercise the transparency variant.
module tb_sprite_draw_scheduler;
  localparam int         NUM_REQ = 4;
  localparam int         ROM_LAT = 1;
  localparam int         TIMEOUT = 16;
  localparam logic [2:0] TRANSP  = 3'b000;
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP_ON = 1'b1;
`else
  localparam bit TRANSP_ON = 1'b0;
`endif

  logic                 clock_all = 1'b0;
  logic                 reset_all;
  logic [NUM_REQ-1:0]   req, src_done, grant, drawer_enable, noise_done;
  logic [9*NUM_REQ-1:0] src_x;
  logic [8*NUM_REQ-1:0] src_y;
  logic [3*NUM_REQ-1:0] src_colour;
  logic [8:0]           vga_x;
  logic [7:0]           vga_y;
  logic [2:0]           vga_colour, done_id;
  logic                 vga_plot, busy, done_pulse, timeout_err;

  sprite_draw_scheduler #(
    .NUM_REQ(NUM_REQ), .ROM_LAT(ROM_LAT), .TIMEOUT(TIMEOUT), .TRANSP_COLOUR(TRANSP)
  ) dut (
    .clock_all(clock_all), .reset_all(reset_all), .req(req), .src_done(src_done),
    .src_x(src_x), .src_y(src_y), .src_colour(src_colour), .grant(grant),
    .drawer_enable(drawer_enable), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done_pulse(done_pulse), .done_id(done_id),
    .timeout_err(timeout_err)
  );

  always #5 clock_all = ~clock_all;

  // Drawer models: counter runs while enabled, clears when not; len 0 never raises done.
  int unsigned len [NUM_REQ];
  int unsigned cnt [NUM_REQ];
  logic [8:0]  base_x [NUM_REQ];
  logic [7:0]  base_y [NUM_REQ];
  logic [2:0]  col_tab [NUM_REQ][4];

  always @(posedge clock_all)
    for (int i = 0; i < NUM_REQ; i++) cnt[i] <= drawer_enable[i] ? cnt[i] + 1 : 0;

  always_comb begin
    src_x      = '0;
    src_y      = '0;
    src_colour = '0;
    src_done   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_x[9*i +: 9]      = base_x[i] + 9'(cnt[i]);
      src_y[8*i +: 8]      = base_y[i];
      src_colour[3*i +: 3] = col_tab[i][cnt[i] % 4];
      src_done[i] = (drawer_enable[i] && len[i] != 0 && cnt[i] == len[i] - 1) || noise_done[i];
    end
  end

  typedef struct packed {logic [8:0] x; logic [7:0] y; logic [2:0] c;} pix_t;
  pix_t pix_q[$];
  int   done_q[$];
  int   compared = 0, mismatched = 0, cycle = 0;
  pix_t mon_exp;
  int   mon_id;

  always @(posedge clock_all) cycle <= cycle + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clock_all) begin
    if (vga_plot === 1'b1) begin
      compared++;
      if (pix_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%b, required no plot", vga_x, vga_y, vga_colour);
      end else begin
        mon_exp = pix_q.pop_front();
        if ({vga_x, vga_y, vga_colour} !== mon_exp) begin
          mismatched++;
          $display("FAIL pixel: got x=%0d y=%0d c=%b, required x=%0d y=%0d c=%b",
                   vga_x, vga_y, vga_colour, mon_exp.x, mon_exp.y, mon_exp.c);
        end
      end
    end
    if (done_pulse === 1'b1) begin
      compared++;
      if (done_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: got done_id=%0d, required no done_pulse", done_id);
      end else begin
        mon_id = done_q.pop_front();
        if (done_id !== 3'(mon_id) || grant !== '0) begin
          mismatched++;
          $display("FAIL done: got id=%0d grant=%b, required id=%0d grant=0000", done_id, grant, mon_id);
        end
      end
    end
    compared++;
    if (!$onehot0(grant) || !$onehot0(drawer_enable) || (drawer_enable & ~grant) !== '0) begin
      mismatched++;
      $display("FAIL onehot: got grant=%b enable=%b, required one-hot0 with enable within grant",
               grant, drawer_enable);
    end
  end

  task automatic push_sprite(input int id, input int n);
    pix_t p;
    for (int k = 0; k < n; k++) begin
      p.x = base_x[id] + 9'(k);
      p.y = base_y[id];
      p.c = col_tab[id][k % 4];
      if (!(TRANSP_ON && p.c == TRANSP)) pix_q.push_back(p);
    end
    done_q.push_back(id);
  endtask

  task automatic set_drawer(input int id, input int n, input int x, input int y, input logic [2:0] c);
    len[id]    = n;
    base_x[id] = 9'(x);
    base_y[id] = 8'(y);
    for (int k = 0; k < 4; k++) col_tab[id][k] = c;
  endtask

  task automatic apply_reset();
    reset_all = 1'b1;
    req       = '0;
    repeat (2) @(negedge clock_all);
    reset_all = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clock_all);
    while ((busy !== 1'b0 || done_q.size() != 0 || pix_q.size() != 0) && n < budget) begin
      @(negedge clock_all);
      n++;
    end
    compared++;
    if (n >= budget) begin
      mismatched++;
      $display("FAIL %s: got busy=%b pix_left=%0d done_left=%0d, required idle and drained",
               name, busy, pix_q.size(), done_q.size());
      pix_q.delete();
      done_q.delete();
    end
  endtask

  task automatic wait_enable(input int id, input int budget, input string name);
    int n = 0;
    while (drawer_enable[id] !== 1'b1 && n < budget) begin
      @(negedge clock_all);
      n++;
    end
    compared++;
    if (n >= budget) begin
      mismatched++;
      $display("FAIL %s: got no drawer_enable[%0d], required it within %0d cycles", name, id, budget);
    end
  endtask

  task automatic test_reset();
    noise_done = '0;
    apply_reset();
    compared++;
    if ({grant, drawer_enable, vga_x, vga_y, vga_colour, vga_plot, busy, done_pulse, done_id, timeout_err} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got grant=%b en=%b x=%0d plot=%b busy=%b done=%b terr=%b, required all 0",
               grant, drawer_enable, vga_x, vga_plot, busy, done_pulse, timeout_err);
    end
  endtask

  task automatic test_single_sprite();
    int t_draw, t_plot, n;
    set_drawer(0, 3, 10, 5, 3'b110);
    push_sprite(0, 3);
    req = 4'b0001;
    @(negedge clock_all);
    wait_enable(0, 20, "single_enable");
    t_draw = cycle;
    req = '0;
    n = 0;
    while (vga_plot !== 1'b1 && n < 20) begin
      @(negedge clock_all);
      n++;
    end
    t_plot = cycle;
    compared++;
    if (t_plot - t_draw != ROM_LAT) begin
      mismatched++;
      $display("FAIL single_latency: got %0d cycles, required %0d", t_plot - t_draw, ROM_LAT);
    end
    wait_idle(30, "single_idle");
    compared++;
    if (timeout_err !== 1'b0) begin
      mismatched++;
      $display("FAIL single_terr: got %b, required 0", timeout_err);
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] prev;
    int n_grants, cyc;
    apply_reset();
    set_drawer(0, 2, 20, 1, 3'b001);
    set_drawer(1, 3, 40, 2, 3'b010);
    set_drawer(3, 1, 300, 3, 3'b011);
    for (int r = 0; r < 2; r++) begin
      push_sprite(0, 2);
      push_sprite(1, 3);
      push_sprite(3, 1);
    end
    noise_done = 4'b0100;
    prev = '0;
    n_grants = 0;
    cyc = 0;
    req = 4'b1011;
    while (n_grants < 6 && cyc < 300) begin
      @(negedge clock_all);
      cyc++;
      if (grant != '0 && prev == '0) begin
        n_grants++;
        if (n_grants == 6) req = '0;
      end
      prev = grant;
    end
    compared++;
    if (n_grants != 6) begin
      mismatched++;
      $display("FAIL rr_grants: got %0d grants, required 6", n_grants);
    end
    wait_idle(60, "rr_idle");
    noise_done = '0;
  endtask

  task automatic test_mid_draw_change();
    int n = 0;
    set_drawer(2, 4, 100, 50, 3'b101);
    push_sprite(2, 4);
    push_sprite(0, 2);
    req = 4'b0100;
    @(negedge clock_all);
    wait_enable(2, 20, "mid_enable");
    req = 4'b0001;
    while (grant[0] !== 1'b1 && n < 40) begin
      @(negedge clock_all);
      n++;
    end
    compared++;
    if (grant !== 4'b0001 || pix_q.size() != 2 || done_q.size() != 1) begin
      mismatched++;
      $display("FAIL mid_order: got grant=%b pix_left=%0d done_left=%0d, required 0001/2/1",
               grant, pix_q.size(), done_q.size());
    end
    req = '0;
    wait_idle(30, "mid_idle");
  endtask

  task automatic test_reset_mid_draw();
    int n = 0;
    set_drawer(0, 20, 200, 7, 3'b111);
    for (int k = 0; k < 4; k++) pix_q.push_back(pix_t'({9'(200 + k), 8'd7, 3'b111}));
    req = 4'b0001;
    @(negedge clock_all);
    wait_enable(0, 20, "rst_enable");
    req = '0;
    repeat (4) @(negedge clock_all);
    reset_all = 1'b1;
    @(negedge clock_all);
    compared++;
    if ({grant, drawer_enable, vga_x, vga_y, vga_colour, vga_plot, busy, done_pulse, done_id, timeout_err} !== '0
        || pix_q.size() != 0) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: got grant=%b en=%b x=%0d plot=%b busy=%b pix_left=%0d, required all 0",
               grant, drawer_enable, vga_x, vga_plot, busy, pix_q.size());
    end
    reset_all = 1'b0;
    repeat (5) begin
      @(negedge clock_all);
      if (vga_plot !== 1'b0 || busy !== 1'b0) n++;
    end
    compared++;
    if (n != 0) begin
      mismatched++;
      $display("FAIL rst_mid_quiet: got %0d active cycles, required 0", n);
    end
    set_drawer(0, 2, 20, 1, 3'b001);
    push_sprite(0, 2);
    req = 4'b1001;
    n = 0;
    while (grant === '0 && n < 20) begin
      @(negedge clock_all);
      n++;
    end
    compared++;
    if (grant !== 4'b0001) begin
      mismatched++;
      $display("FAIL rst_rr_ptr: got grant=%b, required 0001", grant);
    end
    req = '0;
    wait_idle(30, "rst_idle");
  endtask

  task automatic test_timeout();
    apply_reset();
    set_drawer(1, 0, 480, 200, 3'b100);
    push_sprite(1, TIMEOUT);
    req = 4'b0010;
    @(negedge clock_all);
    wait_enable(1, 20, "to_enable");
    req = '0;
    wait_idle(100, "to_idle");
    compared++;
    if (timeout_err !== 1'b1) begin
      mismatched++;
      $display("FAIL to_set: got timeout_err=%b, required 1", timeout_err);
    end
    push_sprite(0, 2);
    req = 4'b0001;
    @(negedge clock_all);
    req = '0;
    wait_idle(30, "to_next_idle");
    compared++;
    if (timeout_err !== 1'b1) begin
      mismatched++;
      $display("FAIL to_sticky: got timeout_err=%b, required 1", timeout_err);
    end
    apply_reset();
    compared++;
    if (timeout_err !== 1'b0) begin
      mismatched++;
      $display("FAIL to_clear: got timeout_err=%b, required 0", timeout_err);
    end
  endtask

  task automatic test_colours();
    set_drawer(1, 3, 60, 9, 3'b000);
    col_tab[1][1] = 3'b101;
    push_sprite(1, 3);
    req = 4'b0010;
    @(negedge clock_all);
    wait_enable(1, 20, "col_enable");
    req = '0;
    wait_idle(30, "col_idle");
  endtask

  initial begin
    reset_all  = 1'b1;
    req        = '0;
    noise_done = '0;
    for (int i = 0; i < NUM_REQ; i++) set_drawer(i, 1, 0, 0, 3'b000);
    test_reset();
    test_single_sprite();
    test_round_robin();
    test_mid_draw_change();
    test_reset_mid_draw();
    test_timeout();
    test_colours();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish within 200000 ns");
    $fatal(1, "simulation time limit");
  end

endmodule
